// File: rtl/mem_refill_fsm.sv
// Data-cache miss controller: optional victim writeback, then a line fill, then a one-cycle cache install.
// Optional perf counters are enabled by defining MEM_REFILL_PERF_CNT_EN.
module mem_refill_fsm #(
    parameter int INDEX_W = 2,
    parameter int TAG_W   = 26,
    parameter int LINE_W  = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       addr,
    input  logic              hit,
    input  logic              dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [LINE_W-1:0] victim_data,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              fill_we,
    output logic [LINE_W-1:0] fill_data,
    output logic [TAG_W-1:0]  fill_tag,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
);

    typedef enum logic [1:0] {IDLE, WB, FILL, UPDATE} state_t;

    state_t            state, state_nx;
    logic              miss;
    logic [31:0]       line_addr, line_addr_nx;
    logic              mem_read_nx, mem_write_nx, fill_we_nx;
    logic [31:0]       mem_addr_nx;
    logic [LINE_W-1:0] mem_wdata_nx, fill_data_nx;
    logic [TAG_W-1:0]  fill_tag_nx;

    assign miss  = (req_read | req_write) & ~hit;
    assign stall = (state != IDLE) | miss;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (miss) state_nx = dirty ? WB : FILL;
            WB:      if (mem_ready) state_nx = FILL;
            FILL:    if (mem_ready) state_nx = UPDATE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs; everything holds unless a transition moves it.
    always_comb begin
        line_addr_nx = line_addr;
        mem_read_nx  = mem_read;
        mem_write_nx = mem_write;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        fill_data_nx = fill_data;
        fill_tag_nx  = fill_tag;
        fill_we_nx   = 1'b0;
        case (state)
            IDLE: if (miss) begin
                line_addr_nx = addr & 32'hFFFF_FFF0;
                if (dirty) begin
                    mem_write_nx = 1'b1;
                    mem_addr_nx  = {victim_tag, addr[INDEX_W+3:4], 4'b0};
                    mem_wdata_nx = victim_data;
                end else begin
                    mem_read_nx  = 1'b1;
                    mem_addr_nx  = addr & 32'hFFFF_FFF0;
                end
            end
            WB: if (mem_ready) begin
                mem_write_nx = 1'b0;
                mem_read_nx  = 1'b1;
                mem_addr_nx  = line_addr;
            end
            FILL: if (mem_ready) begin
                mem_read_nx  = 1'b0;
                fill_data_nx = mem_rdata;
                fill_tag_nx  = line_addr[31:INDEX_W+4];
                fill_we_nx   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_addr <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_we   <= 1'b0;
            fill_data <= '0;
            fill_tag  <= '0;
        end else begin
            line_addr <= line_addr_nx;
            mem_read  <= mem_read_nx;
            mem_write <= mem_write_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            fill_we   <= fill_we_nx;
            fill_data <= fill_data_nx;
            fill_tag  <= fill_tag_nx;
        end
    end

`ifdef MEM_REFILL_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (state == IDLE && state_nx != IDLE) miss_count <= miss_count + 32'd1;
            if (state == WB && state_nx == FILL)   wb_count   <= wb_count + 32'd1;
        end
    end
`else
    assign miss_count = 32'd0;
    assign wb_count   = 32'd0;
`endif

endmodule

// File: tb/tb_mem_refill_fsm.sv
// Scoreboard bench for mem_refill_fsm: stimulus pushes expected memory ops and fills, a monitor pops and compares.
module tb_mem_refill_fsm;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_read, req_write, hit, dirty, mem_ready;
    logic [31:0]  addr;
    logic [25:0]  victim_tag;
    logic [127:0] victim_data, mem_rdata;
    logic         stall, mem_read, mem_write, fill_we;
    logic [31:0]  mem_addr, miss_count, wb_count;
    logic [127:0] mem_wdata, fill_data;
    logic [25:0]  fill_tag;

    mem_refill_fsm dut (
        .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write), .addr(addr),
        .hit(hit), .dirty(dirty), .victim_tag(victim_tag), .victim_data(victim_data),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_we(fill_we),
        .fill_data(fill_data), .fill_tag(fill_tag), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [31:0] a; logic [127:0] d; } mem_op_t;
    typedef struct { logic [25:0] tag; logic [127:0] d; } fill_t;

    mem_op_t exp_mem[$];
    fill_t   exp_fill[$];
    int checks = 0, failures = 0;
    int model_miss = 0, model_wb = 0;

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: values sampled here are those the DUT sees at the coming rising edge.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            if ((mem_write || mem_read) && mem_ready) begin
                mem_op_t op;
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_op", {mem_write, mem_addr}, 0);
                end else begin
                    op = exp_mem.pop_front();
                    chk("mem_op_kind", {mem_write, mem_read}, {op.wr, ~op.wr});
                    chk("mem_addr", mem_addr, op.a);
                    if (op.wr) chk("mem_wdata", mem_wdata, op.d);
                end
            end
            if (fill_we) begin
                fill_t f;
                if (exp_fill.size() == 0) begin
                    chk("unexpected_fill_we", fill_tag, 0);
                end else begin
                    f = exp_fill.pop_front();
                    chk("fill_tag", fill_tag, f.tag);
                    chk("fill_data", fill_data, f.d);
                end
            end
        end
    end

    // One CPU access: model expectations, then play memory with the given ready delays.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a, input bit h, input bit d,
                             input logic [25:0] vt, input logic [127:0] vd, input logic [127:0] rl,
                             input int dwb, input int dfill, input int hold);
        int exp_stall, stalls, wc, rc, cyc;
        bit done;
        @(negedge clk);
        req_read = rd; req_write = wr; addr = a; hit = h; dirty = d;
        victim_tag = vt; victim_data = vd;
        exp_stall = 0;
        if (!h) begin
            if (d) begin
                exp_mem.push_back('{1'b1, {vt, a[5:4], 4'h0}, vd});
                model_wb++;
            end
            exp_mem.push_back('{1'b0, {a[31:4], 4'h0}, '0});
            exp_fill.push_back('{a[31:6], rl});
            model_miss++;
            exp_stall = 1 + (d ? dwb + 1 : 0) + dfill + 1 + 1;
        end
        stalls = 0; wc = 0; rc = 0; cyc = 0; done = 0;
        while (!done && cyc < 300) begin
            mem_rdata = rnd_line();
            if (mem_write) begin
                mem_ready = (wc == dwb); wc++;
            end else if (mem_read) begin
                mem_ready = (rc == dfill);
                if (rc == dfill) mem_rdata = rl;
                rc++;
            end else begin
                mem_ready = 1'($urandom % 2);
            end
            if (fill_we) begin
                addr = a; hit = 1'b1;
            end else if (cyc > 0 && !h) begin
                addr = $urandom; victim_data = rnd_line(); victim_tag = 26'($urandom); dirty = 1'($urandom % 2);
            end
            #1;
            if (stall) stalls++;
            else done = 1;
            cyc++;
            if (!done) @(negedge clk);
        end
        if (!done) chk("timeout_stall_never_dropped", 1, 0);
        chk("stall_cycles", 128'(stalls), 128'(exp_stall));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom % 2);
            #1;
            chk("stall_on_hit", stall, 1'b0);
        end
        @(negedge clk);
        req_read = 0; req_write = 0; hit = 0;
    endtask

    initial begin
        reset = 0; req_read = 0; req_write = 0; addr = 0; hit = 0; dirty = 0;
        victim_tag = 0; victim_data = 0; mem_ready = 0; mem_rdata = 0;
        #12;
        chk("reset_outputs", {stall, mem_read, mem_write, fill_we, mem_addr, miss_count, wb_count}, 0);
        chk("reset_data", {mem_wdata ^ fill_data, fill_tag}, 0);
        @(negedge clk); reset = 1;

        // Clean read miss, ready two cycles after the read strobe.
        do_access(1, 0, 32'h34, 0, 0, 26'h0, rnd_line(), rnd_line(), 0, 2, 1);
        // Dirty write miss with ready held high.
        do_access(0, 1, 32'h100, 0, 1, 26'h5, rnd_line(), rnd_line(), 0, 0, 1);
        // Hit: no memory traffic for ten cycles.
        do_access(1, 0, 32'h2040, 1, 1, 26'h7, rnd_line(), rnd_line(), 0, 0, 10);
        // Dirty miss with slow writeback; addr and victim_data toggle while in WB.
        do_access(1, 1, 32'hDEAD_BEE8, 0, 1, 26'h2AB_CDEF, rnd_line(), rnd_line(), 3, 1, 1);

        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom % 3);
            do_access(k != 1, k != 0, $urandom, ($urandom % 4) == 0, 1'($urandom % 2),
                      26'($urandom), rnd_line(), rnd_line(), int'($urandom % 4), int'($urandom % 4),
                      int'($urandom % 3));
        end

`ifdef MEM_REFILL_PERF_CNT_EN
        chk("miss_count", miss_count, model_miss);
        chk("wb_count", wb_count, model_wb);
`else
        chk("miss_count_tied", miss_count, 0);
        chk("wb_count_tied", wb_count, 0);
`endif

        // Asynchronous reset in the middle of FILL.
        @(negedge clk);
        req_read = 1; addr = 32'h0000_1230; hit = 0; dirty = 0; mem_ready = 0;
        for (int i = 0; i < 5 && !mem_read; i++) begin
            @(negedge clk); mem_ready = 0;
        end
        chk("reached_fill", mem_read, 1'b1);
        #1;
        reset = 0; req_read = 0;
        #1;
        chk("async_reset_strobes", {mem_read, mem_write, fill_we, stall}, 0);
        chk("async_reset_addr", mem_addr, 0);
        exp_mem.delete(); exp_fill.delete();
        model_miss = 0; model_wb = 0;
        @(negedge clk); reset = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1;
            #1;
            chk("post_reset_idle", {fill_we, mem_read, stall}, 0);
        end
        do_access(1, 0, 32'h0000_0ABC, 0, 1, 26'h3, rnd_line(), rnd_line(), 1, 0, 1);

        repeat (3) @(negedge clk);
        chk("mem_queue_drained", 128'(exp_mem.size()), 0);
        chk("fill_queue_drained", 128'(exp_fill.size()), 0);
`ifdef MEM_REFILL_PERF_CNT_EN
        chk("miss_count_after_reset", miss_count, model_miss);
        chk("wb_count_after_reset", wb_count, model_wb);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
